// File: rtl/fifo_load_ctrl_n.sv
// Frame load/drain controller: routes one of NUM_CH channels into a FIFO,
// writes up to LOAD_LEN words, then drains the FIFO automatically or on request.
module fifo_load_ctrl_n #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int LOAD_LEN   = 16,
  parameter int CNT_W      = 5,
  parameter bit AUTO_DRAIN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [CH_W-1:0]  Ch_sel,
  input  logic             Full,
  input  logic             Empty,
  input  logic             Drain,
  input  logic             Abort,
  output logic [CH_W-1:0]  Mux,
  output logic             Write,
  output logic             Read,
  output logic             Ready,
  output logic [CNT_W-1:0] Word_cnt,
  output logic             Err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FRAME  = 3'd1,
    S_LOAD   = 3'd2,
    S_FINISH = 3'd3,
    S_HOLD   = 3'd4,
    S_READ   = 3'd5
  } state_t;

  // One extra bit so NUM_CH == 2**CH_W still compares correctly.
  localparam logic [CH_W:0]    NUM_CH_X = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FRAME;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FRAME: begin
        ch_d  = Ch_sel;
        cnt_d = {CNT_W{1'b0}};
        if ({1'b0, Ch_sel} >= NUM_CH_X) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!Full) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (Abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (Full) begin
          state_d = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FINISH: begin
        if (AUTO_DRAIN) begin
          state_d = S_READ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (Drain) begin
          state_d = S_READ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_READ: begin
        if (Abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (Empty) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= {CH_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output decode; only the strobes look at the FIFO flags.
  always_comb begin
    Mux      = {CH_W{1'b0}};
    Write    = 1'b0;
    Read     = 1'b0;
    Ready    = 1'b0;
    Word_cnt = cnt_q;
    Err      = err_q;
    case (state_q)
      S_IDLE: Ready = 1'b1;
      S_LOAD: begin
        Mux   = ch_q;
        Write = ~Full;
      end
      S_READ: Read = ~Empty;
      default: Ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fifo_load_ctrl_n.sv
// Directed-vector bench for fifo_load_ctrl_n: one auto-drain instance and
// one hold-for-drain instance, each with hand-computed expected values.
module tb_fifo_load_ctrl_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, full, empty, drain, abort;
  logic [2:0] ch_sel;
  logic [2:0] mux;
  logic       write, read, ready, err;
  logic [4:0] word_cnt;

  logic       start_h, full_h, empty_h, drain_h, abort_h;
  logic [2:0] ch_sel_h;
  logic [2:0] mux_h;
  logic       write_h, read_h, ready_h, err_h;
  logic [4:0] word_cnt_h;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_load_ctrl_n #(.NUM_CH(4), .CH_W(3), .LOAD_LEN(16), .CNT_W(5), .AUTO_DRAIN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .Start(start), .Ch_sel(ch_sel), .Full(full), .Empty(empty),
    .Drain(drain), .Abort(abort), .Mux(mux), .Write(write), .Read(read), .Ready(ready),
    .Word_cnt(word_cnt), .Err(err)
  );

  fifo_load_ctrl_n #(.NUM_CH(4), .CH_W(3), .LOAD_LEN(3), .CNT_W(5), .AUTO_DRAIN(1'b0)) dut_h (
    .clk(clk), .reset(reset), .Start(start_h), .Ch_sel(ch_sel_h), .Full(full_h), .Empty(empty_h),
    .Drain(drain_h), .Abort(abort_h), .Mux(mux_h), .Write(write_h), .Read(read_h), .Ready(ready_h),
    .Word_cnt(word_cnt_h), .Err(err_h)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; full = 1'b0; empty = 1'b0; drain = 1'b0; abort = 1'b0; ch_sel = 3'd0;
    start_h = 1'b0; full_h = 1'b0; empty_h = 1'b0; drain_h = 1'b0; abort_h = 1'b0; ch_sel_h = 3'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_read",  32'(read),  32'd0);
    chk("rst_mux",   32'(mux),   32'd0);
    chk("rst_cnt",   32'(word_cnt), 32'd0);
    chk("rst_err",   32'(err),   32'd0);

    // Full-length frame on channel 2, then auto drain.
    ch_sel = 3'd2; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("frame_ready", 32'(ready), 32'd0);
    chk("frame_write", 32'(write), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      chk("load_write", 32'(write), 32'd1);
      chk("load_mux",   32'(mux),   32'd2);
      chk("load_cnt",   32'(word_cnt), 32'(i));
    end
    tick(); #1;
    chk("fin_write", 32'(write), 32'd0);
    chk("fin_mux",   32'(mux),   32'd0);
    chk("fin_cnt",   32'(word_cnt), 32'd16);
    chk("fin_read",  32'(read),  32'd0);
    tick(); #1;
    chk("rd_read", 32'(read), 32'd1);
    tick(); empty = 1'b1; #1;
    chk("rd_empty_read", 32'(read), 32'd0);
    tick(); #1;
    chk("done_ready", 32'(ready), 32'd1);
    chk("done_cnt",   32'(word_cnt), 32'd16);

    // Full rises after five writes on channel 1.
    empty = 1'b0; ch_sel = 3'd1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("full_pre_write", 32'(write), 32'd1);
      chk("full_pre_mux",   32'(mux),   32'd1);
    end
    tick(); full = 1'b1; #1;
    chk("full_write", 32'(write), 32'd0);
    chk("full_cnt",   32'(word_cnt), 32'd5);
    tick(); full = 1'b0; #1;
    chk("full_fin_write", 32'(write), 32'd0);
    chk("full_fin_ready", 32'(ready), 32'd0);
    tick(); #1;
    chk("full_rd_read", 32'(read), 32'd1);
    chk("full_rd_cnt",  32'(word_cnt), 32'd5);
    empty = 1'b1; #1;
    chk("full_rd_empty", 32'(read), 32'd0);
    tick(); #1;
    chk("full_idle", 32'(ready), 32'd1);

    // Invalid channel 5.
    ch_sel = 3'd5; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("bad_frame_write", 32'(write), 32'd0);
    tick(); #1;
    chk("bad_err",   32'(err),   32'd1);
    chk("bad_ready", 32'(ready), 32'd1);
    chk("bad_write", 32'(write), 32'd0);

    // Next Start clears Err; Abort with Full at Word_cnt=3.
    ch_sel = 3'd1; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("clr_err", 32'(err), 32'd0);
    repeat (4) tick();
    full = 1'b1; abort = 1'b1; #1;
    chk("abt_write", 32'(write), 32'd0);
    chk("abt_cnt_pre", 32'(word_cnt), 32'd3);
    tick(); full = 1'b0; abort = 1'b0; #1;
    chk("abt_ready", 32'(ready), 32'd1);
    chk("abt_err",   32'(err),   32'd1);
    chk("abt_cnt",   32'(word_cnt), 32'd3);

    // Reset mid-LOAD at Word_cnt=7.
    empty = 1'b0; ch_sel = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    repeat (8) tick();
    #1;
    chk("pre_rst_cnt",   32'(word_cnt), 32'd7);
    chk("pre_rst_write", 32'(write), 32'd1);
    reset = 1'b1; #1;
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_cnt",   32'(word_cnt), 32'd0);
    chk("mid_rst_err",   32'(err),   32'd0);
    chk("mid_rst_mux",   32'(mux),   32'd0);
    tick(); reset = 1'b0;

    // Hold-for-drain instance: 3-word frame, then wait for Drain.
    ch_sel_h = 3'd0; start_h = 1'b1;
    tick(); start_h = 1'b0;
    repeat (3) tick();
    #1;
    chk("h_last_write", 32'(write_h), 32'd1);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("h_hold_read",  32'(read_h),  32'd0);
      chk("h_hold_ready", 32'(ready_h), 32'd0);
      tick();
    end
    drain_h = 1'b1;
    tick(); drain_h = 1'b0; #1;
    chk("h_drain_read", 32'(read_h), 32'd1);
    chk("h_cnt", 32'(word_cnt_h), 32'd3);
    empty_h = 1'b1; #1;
    chk("h_empty_read", 32'(read_h), 32'd0);
    tick(); #1;
    chk("h_idle", 32'(ready_h), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_load_ctrl_n.md
Name: fifo_load_ctrl_n

Overview:
- Parametrised successor to the two-channel FIFO load/read controller.
- Sequences one acquisition frame:
  - selects one of NUM_CH source channels onto the FIFO write mux;
  - writes up to LOAD_LEN words, stopping early on FIFO Full;
  - drains the FIFO automatically or on command.
- Adds a word counter, an abort path, an invalid-channel error flag and a selectable drain mode.
- Sits between the frame sequencer (Start/Ch_sel) and a single-clock FIFO (Full/Empty, Write/Read).

Parameters:
- NUM_CH, 4: number of source channels, 2..2**CH_W.
- CH_W, 2: width of the channel select and mux code.
- LOAD_LEN, 16: maximum words written per frame, 1..2**CNT_W-1.
- CNT_W, 5: width of the word counter.
- AUTO_DRAIN, 1: 1 = FINISH goes straight to READ; 0 = FINISH waits in HOLD for Drain.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  frame request, sampled in IDLE.
- Ch_sel  in  CH_W  requested channel, sampled in FRAME.
- Full  in  1  FIFO full flag.
- Empty  in  1  FIFO empty flag.
- Drain  in  1  drain request, sampled in HOLD only.
- Abort  in  1  terminate the current frame.
- Mux  out  CH_W  channel code driving the FIFO input mux.
- Write  out  1  FIFO write strobe.
- Read  out  1  FIFO read strobe.
- Ready  out  1  controller idle, accepts Start.
- Word_cnt  out  CNT_W  words written in the current or last frame.
- Err  out  1  sticky error flag, cleared by the next accepted Start.

Behaviour:
- Reset (async, high): state=IDLE, Ready=1, Mux=0, Write=0, Read=0, Word_cnt=0, Err=0, ch_reg=0.
  - Reset asserted mid-frame forces these values immediately; no write/read strobe survives past the reset edge.
- Encoding: states are IDLE, FRAME, LOAD, FINISH, HOLD, READ. Unused encodings return to IDLE next cycle with all strobes 0.
- IDLE:
  - Ready=1; all strobes 0; Mux=0.
  - Start=1 -> FRAME; Err cleared on the same edge.
- FRAME (1 cycle):
  - Ready=0; ch_reg<=Ch_sel; Word_cnt<=0.
  - Ch_sel>=NUM_CH -> Err<=1, go to IDLE.
  - Otherwise -> LOAD.
- LOAD:
  - Mux=ch_reg; Write = ~Full (combinational gate, no write into a full FIFO).
  - Word_cnt increments on every cycle with Write=1.
  - Exit priority:
    - Abort -> IDLE, Err<=1.
    - Else Full -> FINISH.
    - Else a write with Word_cnt==LOAD_LEN-1 -> FINISH (Word_cnt ends at LOAD_LEN).
    - Else stay in LOAD.
  - Latency: Start at edge n gives FRAME at n+1 and the first Write at n+2.
- FINISH (1 cycle):
  - All strobes 0; Mux=0.
  - AUTO_DRAIN=1 -> READ; AUTO_DRAIN=0 -> HOLD.
- HOLD:
  - All strobes 0.
  - Abort -> IDLE, Err<=1.
  - Else Drain=1 -> READ.
- READ:
  - Read = ~Empty.
  - Abort -> IDLE, Err<=1.
  - Else Empty=1 -> IDLE.
  - Word_cnt holds its value through READ and IDLE until the next FRAME.
- Simultaneous events:
  - Abort dominates Full, count, Drain and Empty.
  - Start outside IDLE is ignored.
  - Abort in IDLE or FRAME is ignored.
- Output decode: Mux, Ready and Word_cnt depend on state and registers only. Write and Read additionally gate on Full and Empty.

Test Plan:
- Reset mid-LOAD with Word_cnt=7 -> same cycle: Write=0, Ready=1, Word_cnt=0, Err=0.
- LOAD_LEN=16, Ch_sel=2, Full=0, Start pulse at cycle 0 -> Write high cycles 2..17 with Mux=2, Word_cnt=16, FINISH at 18, then Read high until Empty, Ready=1 after.
- Full rises after 5 writes (Ch_sel=1) -> Write drops the same cycle, Word_cnt=5, FINISH then READ.
- Ch_sel=5 with NUM_CH=4 -> FRAME then IDLE, Err=1, Write never asserted; the next Start clears Err.
- Abort in LOAD at Word_cnt=3, with Full=1 on the same cycle -> IDLE, Err=1, Word_cnt=3.
- AUTO_DRAIN=0 -> controller sits in HOLD with Read=0 for 10 cycles; Drain pulse -> Read=1 next cycle; Empty=1 -> IDLE.
